dmem_arbiter: RTL and testbench

- Two-port request/acknowledge arbiter that shares the single-port data memory between port 0 (CPU load/store stage) and port 1 (program loader / debug DMA).
- Drives the memory's mem_read, mem_write, addr and write_data, and captures its combinational read_data into a per-transaction response register.
- Round-robin fairness, an optional lock that holds the grant for read-modify-write sequences, and out-of-range address detection.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/rr_pick2.sv | 30 +++
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and its round-robin picker.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 10;
  localparam int DMEM_DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick with an optional grant lock.
// A lock only binds while its owner keeps requesting; otherwise normal round-robin applies.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       lock_valid_i,
  input  logic       lock_port_i,
  output logic       winner_o,
  output logic       valid_o
);

  always_comb begin
    winner_o = 1'b0;
    valid_o  = 1'b0;
    if (lock_valid_i && req_i[lock_port_i]) begin
      winner_o = lock_port_i;
      valid_o  = 1'b1;
    end else if (req_i == 2'b11) begin
      winner_o = ~last_grant_i;
      valid_o  = 1'b1;
    end else if (req_i[0]) begin
      winner_o = 1'b0;
      valid_o  = 1'b1;
    end else if (req_i[1]) begin
      winner_o = 1'b1;
      valid_o  = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: IDLE -> ACCESS -> RESP per transaction.
// Define DMEM_ARB_STATS_EN to add saturating grant/conflict counter outputs.
// Handshake: pN_req with stable we/addr/wdata/lock is held until the one-cycle pN_ack;
// req is sampled only in IDLE, so a requester may drop or change it on the edge after ack.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [31:0]       p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [31:0]       p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output arb_state_t        dbg_state
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       p0_grants,
  output logic [31:0]       p1_grants,
  output logic [31:0]       conflicts
`endif
);

  arb_state_t        state_q, state_d;
  logic              port_q;
  logic              we_q;
  logic              lock_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              last_grant_q;
  logic              lock_valid_q;
  logic              lock_port_q;

  logic       pick;
  logic       pick_valid;
  logic [1:0] req;
  logic       in_range;

  assign req      = {p1_req, p0_req};
  assign in_range = (addr_q[31:ADDR_W] == '0);

  rr_pick2 u_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .lock_valid_i (lock_valid_q),
    .lock_port_i  (lock_port_q),
    .winner_o     (pick),
    .valid_o      (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      port_q       <= PORT_CPU;
      we_q         <= 1'b0;
      lock_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      last_grant_q <= PORT_DMA;
      lock_valid_q <= 1'b0;
      lock_port_q  <= PORT_CPU;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          // An owner that stops requesting gives up its lock.
          if (lock_valid_q && !req[lock_port_q]) lock_valid_q <= 1'b0;
          if (pick_valid) begin
            port_q  <= pick;
            we_q    <= pick ? p1_we    : p0_we;
            lock_q  <= pick ? p1_lock  : p0_lock;
            addr_q  <= pick ? p1_addr  : p0_addr;
            wdata_q <= pick ? p1_wdata : p0_wdata;
          end
        end
        ACCESS: begin
          err_q <= !in_range;
          if (!in_range)  rdata_q <= '0;
          else if (!we_q) rdata_q <= mem_rdata;
        end
        RESP: begin
          last_grant_q <= port_q;
          lock_valid_q <= lock_q;
          lock_port_q  <= port_q;
        end
        default: ;
      endcase
    end
  end

  // Memory strobes come straight from the state so a reset drops them at once.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ACCESS && in_range) begin
      mem_read  = !we_q;
      mem_write = we_q;
      mem_addr  = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W-1:0]};
      mem_wdata = wdata_q;
    end
  end

  assign p0_ack    = (state_q == RESP) && (port_q == PORT_CPU);
  assign p1_ack    = (state_q == RESP) && (port_q == PORT_DMA);
  assign p0_err    = p0_ack && err_q;
  assign p1_err    = p1_ack && err_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] p0_grants_q, p1_grants_q, conflicts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_grants_q <= '0;
      p1_grants_q <= '0;
      conflicts_q <= '0;
    end else begin
      if (p0_ack && p0_grants_q != '1) p0_grants_q <= p0_grants_q + 32'd1;
      if (p1_ack && p1_grants_q != '1) p1_grants_q <= p1_grants_q + 32'd1;
      if (state_q == IDLE && req == 2'b11 && !lock_valid_q && conflicts_q != '1)
        conflicts_q <= conflicts_q + 32'd1;
    end
  end

  assign p0_grants = p0_grants_q;
  assign p1_grants = p1_grants_q;
  assign conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural memory, port drivers, ack scoreboard.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int EW = DW + 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          p0_req, p0_we, p0_lock, p0_ack, p0_err;
  logic          p1_req, p1_we, p1_lock, p1_ack, p1_err;
  logic [31:0]   p0_addr, p1_addr, mem_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, rdata, mem_wdata, mem_rdata;
  logic          mem_read, mem_write, busy;
  arb_state_t    dbg_state;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]   p0_grants, p1_grants, conflicts;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int            ack_cyc[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  int            t0, rd0, wr0;

  dmem_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_lock   (p0_lock),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_ack    (p0_ack),
    .p0_err    (p0_err),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_lock   (p1_lock),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_ack    (p1_ack),
    .p1_err    (p1_err),
    .rdata     (rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef DMEM_ARB_STATS_EN
    ,
    .p0_grants (p0_grants),
    .p1_grants (p1_grants),
    .conflicts (conflicts)
`endif
  );

  // Clock, cycle counter and behavioural single-port memory
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  assign mem_rdata = mem[mem_addr[AW-1:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[AW-1:0]] = mem_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ack(input bit port, input bit err, input logic [DW-1:0] rd);
    exp_q.push_back({port, err, rd});
  endtask

  // Driver: present one transaction, wait for its ack, release req on the following edge
  task automatic txn(input bit port, input bit we, input logic [31:0] addr,
                     input logic [DW-1:0] wd, input bit lock);
    bit got;
    got = 1'b0;
    if (!port) begin
      p0_we = we; p0_addr = addr; p0_wdata = wd; p0_lock = lock; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_addr = addr; p1_wdata = wd; p1_lock = lock; p1_req = 1'b1;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = port ? p1_ack : p0_ack;
    end
    if (!got) check(port ? "p1_ack_timeout" : "p0_ack_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if (!port) p0_req = 1'b0;
    else       p1_req = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (p0_ack || p1_ack) begin
        ack_cyc.push_back(cyc);
        check("ack_exclusive", {63'd0, p0_ack & p1_ack}, 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("ack_port", {63'd0, p1_ack}, {63'd0, mon_e[EW-1]});
          check("ack_err", {63'd0, (p0_ack ? p0_err : p1_err)}, {63'd0, mon_e[EW-2]});
          check("ack_rdata", {32'd0, rdata}, {32'd0, mon_e[DW-1:0]});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[2] = 32'd5;
    mem[4] = 32'd2;
    mem[6] = 32'd7;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    check("rst_mem_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_acks", {60'd0, p0_ack, p0_err, p1_ack, p1_err}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single read: ack in the third cycle, one mem_read cycle
    ack_cyc.delete();
    rd0 = rd_cnt;
    t0 = cyc;
    expect_ack(1'b0, 1'b0, 32'd5);
    txn(1'b0, 1'b0, 32'd2, '0, 1'b0);
    check("single_read_mem_read_cycles", 64'(rd_cnt - rd0), 64'd1);
    check("single_read_latency", (ack_cyc.size() == 1) ? 64'(ack_cyc[0] - t0) : 64'hFFFF, 64'd2);

    // Write then read back; write leaves rdata unchanged
    wr0 = wr_cnt;
    expect_ack(1'b1, 1'b0, 32'd5);
    txn(1'b1, 1'b1, 32'd31, 32'hDEADBEEF, 1'b0);
    expect_ack(1'b0, 1'b0, 32'hDEADBEEF);
    txn(1'b0, 1'b0, 32'd31, '0, 1'b0);
    check("write_mem_write_cycles", 64'(wr_cnt - wr0), 64'd1);
    check("write_mem_content", {32'd0, mem[31]}, 64'hDEADBEEF);

    // Contention from reset: p0 wins the first tie, then grants alternate 3 cycles apart
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rerst_rdata", {32'd0, rdata}, 64'd0);
    ack_cyc.delete();
    expect_ack(1'b0, 1'b0, 32'd5);
    expect_ack(1'b1, 1'b0, 32'hDEADBEEF);
    expect_ack(1'b0, 1'b0, 32'd2);
    expect_ack(1'b1, 1'b0, 32'd7);
    fork
      begin
        txn(1'b0, 1'b0, 32'd2, '0, 1'b0);
        txn(1'b0, 1'b0, 32'd4, '0, 1'b0);
      end
      begin
        txn(1'b1, 1'b0, 32'd31, '0, 1'b0);
        txn(1'b1, 1'b0, 32'd6, '0, 1'b0);
      end
    join
    check("contention_ack_count", 64'(ack_cyc.size()), 64'd4);
    if (ack_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check("contention_ack_spacing", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'd3);
    end

    // Lock: p1 locked read then unlocked write; p0 waits through both
    expect_ack(1'b1, 1'b0, 32'd2);
    expect_ack(1'b1, 1'b0, 32'd2);
    expect_ack(1'b0, 1'b0, 32'd3);
    fork
      begin
        txn(1'b1, 1'b0, 32'd4, '0, 1'b1);
        txn(1'b1, 1'b1, 32'd4, 32'd3, 1'b0);
      end
      begin
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 32'd4, '0, 1'b0);
      end
    join
    check("lock_mem_content", {32'd0, mem[4]}, 64'd3);

    // Out-of-range address: no memory strobes, err with rdata cleared
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    expect_ack(1'b0, 1'b1, 32'd0);
    txn(1'b0, 1'b0, 32'h400, '0, 1'b0);
    check("oor_mem_strobes", 64'((rd_cnt - rd0) + (wr_cnt - wr0)), 64'd0);

    // Reset during ACCESS of a write: strobes drop immediately, memory untouched
    p1_we = 1'b1; p1_addr = 32'd6; p1_wdata = 32'h99; p1_lock = 1'b0; p1_req = 1'b1;
    @(posedge clk); #2;
    check("midop_write_active", {63'd0, mem_write}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("midop_rst_busy", {63'd0, busy}, 64'd0);
    check("midop_rst_mem_write", {63'd0, mem_write}, 64'd0);
    check("midop_rst_mem_bus", {mem_addr, mem_wdata}, 64'd0);
    check("midop_rst_outputs", {rdata, 30'd0, p0_ack, p1_ack}, 64'd0);
    p1_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midop_mem_kept", {32'd0, mem[6]}, 64'd7);
    expect_ack(1'b1, 1'b0, 32'd7);
    txn(1'b1, 1'b0, 32'd6, '0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
